life_sequencer: RTL and testbench

//  Run/pause/step controller for the 8x8 Game of Life pipeline (mux -> evolve datapath -> grid flop).

---
 rtl/life_sequencer.sv | 121 ++++++++++++
 tb/tb_life_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/life_sequencer.sv
// Run/pause/step/halt controller for the 8x8 Game of Life pipeline.
// Paces generations, counts them and flags extinct or still-life grids.
module life_sequencer #(
  parameter int TICK_DIV  = 25_000_000,
  parameter int GEN_W     = 16,
  parameter bit AUTO_HALT = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_btn,
  input  logic             pause_btn,
  input  logic             step_btn,
  input  logic             clear_btn,
  input  logic [63:0]      grid_in,
  output logic             muxStart,
  output logic             floprReset,
  output logic             showShiftSeed,
  output logic             evolve_en,
  output logic [GEN_W-1:0] gen_count,
  output logic             extinct,
  output logic             stable,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam int            PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  state_t        st, nxt;
  logic [PW-1:0] pre, pre_nxt;
  logic [63:0]   prev_grid;
  logic          chk, chk_load;
  logic          chk_fire, ext_now, stab_now, halt_now, evolve_nxt;

  assign state = st;

  always_comb begin
    nxt      = st;
    pre_nxt  = pre;
    ext_now  = (grid_in == 64'd0);
    // the check right after a load has no previous generation to compare
    stab_now = !chk_load && (grid_in == prev_grid);
    chk_fire = chk && (st == S_RUN || st == S_PAUSE);
    halt_now = AUTO_HALT && chk_fire && (ext_now || stab_now);

    if (clear_btn)      nxt = S_IDLE;
    else if (start_btn) nxt = S_LOAD;
    else if (halt_now)  nxt = S_HALT;
    else begin
      case (st)
        S_LOAD:  nxt = S_RUN;
        S_RUN:   if (pause_btn) nxt = S_PAUSE;
        S_PAUSE: if (pause_btn) nxt = S_RUN;
        default: nxt = st;
      endcase
    end

    if (nxt == S_LOAD || nxt == S_IDLE)
      pre_nxt = '0;
    else if (st == S_RUN && nxt == S_RUN)
      pre_nxt = (pre == PRE_MAX) ? '0 : pre + PW'(1);

    // never evolve in a check cycle, so a halt decision always lands first
    evolve_nxt = (nxt == S_LOAD) ||
                 (!evolve_en && ((nxt == S_RUN && pre_nxt == PRE_MAX) ||
                                 (st == S_PAUSE && nxt == S_PAUSE && step_btn)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st            <= S_IDLE;
      pre           <= '0;
      muxStart      <= 1'b0;
      floprReset    <= 1'b1;
      showShiftSeed <= 1'b1;
      evolve_en     <= 1'b0;
      gen_count     <= '0;
      extinct       <= 1'b0;
      stable        <= 1'b0;
      prev_grid     <= '0;
      chk           <= 1'b0;
      chk_load      <= 1'b0;
    end else begin
      st            <= nxt;
      pre           <= pre_nxt;
      muxStart      <= (nxt == S_LOAD);
      floprReset    <= (nxt == S_IDLE);
      showShiftSeed <= (nxt == S_IDLE || nxt == S_LOAD);
      evolve_en     <= evolve_nxt;
      chk           <= evolve_en;
      chk_load      <= evolve_en && (st == S_LOAD);
      if (evolve_en)
        prev_grid <= (st == S_LOAD) ? 64'd0 : grid_in;

      if (clear_btn) begin
        gen_count <= '0;
        extinct   <= 1'b0;
        stable    <= 1'b0;
      end else if (st == S_LOAD) begin
        gen_count <= GEN_W'(1);
        extinct   <= 1'b0;
        stable    <= 1'b0;
      end else begin
        if (evolve_en && gen_count != '1)
          gen_count <= gen_count + GEN_W'(1);
        if (chk_fire) begin
          extinct <= ext_now;
          stable  <= stab_now;
        end
      end
    end
  end

endmodule

// File: tb/tb_life_sequencer.sv
// Scoreboard bench for life_sequencer: models the grid flop and evolve datapath,
// queues expected evolve events and checks them from an independent monitor.
module tb_life_sequencer;
  localparam int TD = 4;
  localparam int GW = 16;

  localparam logic [63:0] VERT  = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
  localparam logic [63:0] HORZ  = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
  localparam logic [63:0] BLOCK = (64'd1 << 27) | (64'd1 << 28) | (64'd1 << 35) | (64'd1 << 36);
  localparam logic [63:0] CELL  = (64'd1 << 36);

  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, PAUSE = 3'd3, HALT = 3'd4;

  logic          clk = 1'b0, reset_n = 1'b1;
  logic          start_btn = 1'b0, pause_btn = 1'b0, step_btn = 1'b0, clear_btn = 1'b0;
  logic [63:0]   grid = '0, seed = '0;
  logic          muxStart, floprReset, showShiftSeed, evolve_en, extinct, stable;
  logic [GW-1:0] gen_count;
  logic [2:0]    state;

  life_sequencer #(.TICK_DIV(TD), .GEN_W(GW), .AUTO_HALT(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .start_btn(start_btn), .pause_btn(pause_btn),
    .step_btn(step_btn), .clear_btn(clear_btn), .grid_in(grid), .muxStart(muxStart),
    .floprReset(floprReset), .showShiftSeed(showShiftSeed), .evolve_en(evolve_en),
    .gen_count(gen_count), .extinct(extinct), .stable(stable), .state(state)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [63:0] life(input logic [63:0] g);
    logic [63:0] n;
    n = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        int k;
        k = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
              k += int'(g[(r + dr) * 8 + c + dc]);
        n[r * 8 + c] = g[r * 8 + c] ? (k == 2 || k == 3) : (k == 3);
      end
    return n;
  endfunction

  // external grid flop + datapath
  always @(posedge clk)
    if (floprReset)     grid <= '0;
    else if (evolve_en) grid <= life(muxStart ? seed : grid);

  typedef struct {
    logic [2:0]  st;
    int          gen;
    logic [63:0] g;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic push(input logic [2:0] st, input int gen, input logic [63:0] g, input int cyc);
    exp_t e;
    e.st = st; e.gen = gen; e.g = g; e.cyc = cyc;
    sbq.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic press(input bit s, input bit p, input bit t, input bit c);
    start_btn = s; pause_btn = p; step_btn = t; clear_btn = c;
    cyc(1);
    start_btn = 0; pause_btn = 0; step_btn = 0; clear_btn = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, state, IDLE);
    chk({tag, "_floprReset"}, floprReset, 1);
    chk({tag, "_showShiftSeed"}, showShiftSeed, 1);
    chk({tag, "_muxStart"}, muxStart, 0);
    chk({tag, "_evolve_en"}, evolve_en, 0);
    chk({tag, "_gen_count"}, gen_count, 0);
    chk({tag, "_extinct"}, extinct, 0);
    chk({tag, "_stable"}, stable, 0);
  endtask

  // monitor: every evolve pulse consumes one expectation; the next cycle shows its result
  exp_t mon_cur;
  bit   mon_pend = 0;
  initial forever begin
    @(negedge clk);
    if (!reset_n) mon_pend = 0;
    else begin
      if (mon_pend) begin
        chk("gen_after_evolve", gen_count, mon_cur.gen);
        chk("grid_after_evolve", grid, mon_cur.g);
        mon_pend = 0;
      end
      if (evolve_en) begin
        if (sbq.size() == 0) chk("unexpected_evolve", evolve_en, 0);
        else begin
          mon_cur = sbq.pop_front();
          chk("evolve_state", state, mon_cur.st);
          if (mon_cur.cyc >= 0) chk("evolve_cycle", cyc_cnt, mon_cur.cyc);
          mon_pend = 1;
        end
      end
    end
  end

  int c0, m;
  initial begin
    #2 reset_n = 0;
    #1 check_reset_vals("por");
    @(posedge clk); @(posedge clk); #3 reset_n = 1;
    cyc(1);

    // pause/step ignored in IDLE
    press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    cyc(2);
    chk("idle_ignores_pause_step", state, IDLE);

    // blinker: evolve every TD cycles, oscillates, never stable
    seed = VERT; c0 = cyc_cnt;
    push(LOAD, 1, HORZ, c0 + 1);
    push(RUN, 2, VERT, c0 + 5);
    push(RUN, 3, HORZ, c0 + 9);
    push(RUN, 4, VERT, c0 + 13);
    press(1, 0, 0, 0);
    cyc(13);
    chk("blinker_state", state, RUN);
    chk("blinker_stable", stable, 0);
    chk("blinker_extinct", extinct, 0);
    chk("blinker_showShiftSeed", showShiftSeed, 0);
    press(0, 0, 0, 1);
    chk("clear_state", state, IDLE);
    chk("clear_gen", gen_count, 0);
    cyc(6);
    chk("blinker_queue_drained", sbq.size(), 0);

    // block: still life halts after generation 2
    seed = BLOCK; c0 = cyc_cnt;
    push(LOAD, 1, BLOCK, c0 + 1);
    push(RUN, 2, BLOCK, c0 + 5);
    press(1, 0, 0, 0);
    cyc(6);
    chk("block_state", state, HALT);
    chk("block_stable", stable, 1);
    chk("block_extinct", extinct, 0);
    chk("block_gen", gen_count, 2);
    cyc(12);
    chk("block_halt_no_evolve", sbq.size(), 0);
    chk("block_halt_held", state, HALT);

    // single cell dies at generation 1
    seed = CELL; c0 = cyc_cnt;
    push(LOAD, 1, 64'd0, c0 + 1);
    press(1, 0, 0, 0);
    cyc(2);
    chk("cell_state", state, HALT);
    chk("cell_extinct", extinct, 1);
    chk("cell_stable", stable, 0);
    chk("cell_gen", gen_count, 1);
    chk("cell_grid", grid, 64'd0);

    // pause, three single steps, resume with held prescaler
    seed = VERT; c0 = cyc_cnt;
    push(LOAD, 1, HORZ, c0 + 1);
    push(RUN, 2, VERT, c0 + 5);
    press(1, 0, 0, 0);
    cyc(6);
    press(0, 1, 0, 0);
    chk("pause_state", state, PAUSE);
    cyc(8);
    chk("pause_no_evolve", sbq.size(), 0);
    for (int i = 0; i < 3; i++) begin
      push(PAUSE, 3 + i, (i % 2 == 0) ? HORZ : VERT, cyc_cnt + 1);
      press(0, 0, 1, 0);
      cyc(3);
    end
    chk("step_gen", gen_count, 5);
    chk("step_state", state, PAUSE);
    m = cyc_cnt;
    push(RUN, 6, VERT, m + 3);
    press(0, 1, 0, 0);
    chk("resume_state", state, RUN);
    cyc(3);
    // clear and start together: clear wins
    press(1, 0, 0, 1);
    chk("clr_start_state", state, IDLE);
    chk("clr_start_gen", gen_count, 0);
    chk("clr_start_floprReset", floprReset, 1);
    cyc(6);
    chk("clr_start_queue_drained", sbq.size(), 0);

    // asynchronous reset in the middle of RUN
    seed = VERT; c0 = cyc_cnt;
    push(LOAD, 1, HORZ, c0 + 1);
    press(1, 0, 0, 0);
    cyc(2);
    #2 reset_n = 0;
    #1 check_reset_vals("midrun");
    @(posedge clk); #3 reset_n = 1;
    cyc(2);
    chk("post_reset_state", state, IDLE);
    chk("post_reset_grid", grid, 64'd0);
    chk("final_queue_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
